keypad_col_scan: RTL and testbench
==================================

Name: keypad_col_scan

Overview:
Active column driver for the 4x4 matrix keypad; the driving counterpart of the row-reading path.
- Walks one active-low column at a time and synchronises the row lines `fil`.
- Debounces a detected key and encodes it to a 4-bit key code.
- Presents the code with a valid/ack handshake to the data-push/storage path.
- Sits between the keypad pins and the calculator's entry logic.

Parameters:
- SCAN_DIV, 27000: clock cycles each column stays driven (dwell). Must be ≥ 4.
- DEB_CYCLES, 270000: consecutive stable cycles needed for press or release acceptance. Must be ≥ 2.

Ports:
- clk  input  1: system clock.
- rst  input  1: synchronous, active-high reset.
- fil  input  4: keypad rows, active-low, pulled up, asynchronous to clk.
- col  output 4: keypad columns, one-hot active-low.
- key_code  output 4: encoded key, valid while key_valid=1.
- key_valid  output 1: key available, level signal.
- key_ack  input  1: consumer accepted key, one-cycle pulse.

Behaviour:
- Reset values: col=4'b1110, key_code=4'h0, key_valid=0, state=SCAN, all counters 0, sync flops 4'hF.
- rst at any point, including mid-debounce or while key_valid=1, applies the reset values at that edge.
- fil passes through a 2-flop synchroniser giving fs. All decisions use fs.
- SCAN state:
  - The column counter advances every SCAN_DIV cycles in the order 1110→1101→1011→0111→1110.
  - fs is sampled only on the last dwell cycle of each column.
  - If fs≠4'hF on that cycle: latch the row index (lowest index of a 0 bit wins on multiple rows), latch the column index and the fs pattern. Go to DEBOUNCE. col is frozen.
- DEBOUNCE state:
  - The counter increments each cycle that fs equals the latched pattern.
  - Any mismatch clears the counter and returns to SCAN, dwell restarted on the same column.
  - When the count reaches DEB_CYCLES, register key_code and set key_valid=1, then go to WAIT_ACK.
  - Latency: key_valid rises DEB_CYCLES+1 cycles after the detecting sample.
- WAIT_ACK state:
  - key_valid and key_code are held, even if the key is released.
  - key_ack is sampled only while key_valid=1. key_ack while key_valid=0 is ignored.
  - On key_ack=1, clear key_valid at the next edge and go to RELEASE.
- RELEASE state:
  - Requires DEB_CYCLES consecutive cycles of fs=4'hF. Any 0 clears the counter.
  - Then go to SCAN, advancing to the next column with a fresh dwell.
  - A held key therefore yields exactly one key_valid.
- Keymap (row r = fil bit, col c = col bit); codes are hex values:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0 (*→E), 0, F (#), D. Specifically: r3c0=E, r3c1=0, r3c2=F, r3c3=D.
- Counter widths: $clog2 of the respective parameter plus 1. No wrap-around is reachable because every counter is cleared on each state change.

Decomposition:
- Shared package keypad_pkg, containing:
  - enum scan_state_t {SCAN, DEBOUNCE, WAIT_ACK, RELEASE};
  - KEYMAP, a 16-entry 4-bit constant indexed {row,col};
  - COL_INIT = 4'b1110.
- One sub-module, sync2 (2-flop synchroniser, width parameter). Reuse it elsewhere for async inputs.

Test Plan (SCAN_DIV=4, DEB_CYCLES=8):
- Column walk: no key pressed, 20 cycles after reset → col sequence 1110,1101,1011,0111,1110 with 4 cycles each; key_valid stays 0.
- Clean press: fil=4'b1101 held while col=1011 (r1,c2) → key_valid=1 with key_code=4'h6, 9 cycles after the detecting sample; col frozen at 1011 throughout.
- Bounce reject: fil toggles 1101/1111 every 3 cycles for 40 cycles → key_valid never asserts; scanning resumes.
- Handshake: key held, no ack for 50 cycles → key_valid=1 and code stable. Then ack pulse → key_valid=0 next cycle, and no second valid until fil=1111 for 8 cycles.
- Multi-row: fil=4'b0110 on col=0111 (r0 and r3 on c3) → key_code=4'hA (lowest row wins).
- Reset mid-operation: rst=1 at debounce count 5 → next edge col=1110, key_valid=0, and a fresh press is then reported normally.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad column scanner.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, WAIT_ACK, RELEASE} scan_state_t;

   localparam logic [3:0] COL_INIT = 4'b1110;

   // Indexed {row,col}; entry 0 is r0c0, entry 15 is r3c3.
   localparam logic [15:0][3:0] KEYMAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   // Index of the lowest zero bit; scanning downwards lets the lowest index win.
   function automatic logic [1:0] low_zero_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs, one flop chain per bit.
module sync2 #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_q;
      logic sync_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            meta_q <= RST_VAL[gi];
            sync_q <= RST_VAL[gi];
         end else begin
            meta_q <= d_i[gi];
            sync_q <= meta_q;
         end
      end

      assign q_o[gi] = sync_q;
   end

endmodule

// File: rtl/keypad_col_scan.sv
// 4x4 keypad column driver: scans columns, debounces a press, encodes it and
// hands the code over with a valid/ack handshake, then waits for release.
module keypad_col_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 27000,
   parameter int DEB_CYCLES = 270000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] fil,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack
);

   localparam int DW  = $clog2(SCAN_DIV) + 1;
   localparam int DBW = $clog2(DEB_CYCLES) + 1;
   localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DEB_DONE   = DBW'(DEB_CYCLES);
   localparam logic [DBW-1:0] REL_LAST   = DBW'(DEB_CYCLES - 1);

   logic [3:0]  fs;
   scan_state_t state_q;
   logic [3:0]  col_q;
   logic [DW-1:0]  dwell_q;
   logic [DBW-1:0] deb_q;
   logic [3:0]  pat_q;
   logic [1:0]  row_q;
   logic [1:0]  colx_q;
   logic [3:0]  key_code_q;
   logic        key_valid_q;
   logic [3:0]  col_next_d;
   logic        rows_idle_d;

   sync2 #(.WIDTH(4), .RST_VAL(4'hF)) u_fil_sync (
      .clk (clk),
      .rst (rst),
      .d_i (fil),
      .q_o (fs)
   );

   assign col_next_d  = {col_q[2:0], col_q[3]};
   assign rows_idle_d = (fs == 4'hF);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCAN;
         col_q       <= COL_INIT;
         dwell_q     <= '0;
         deb_q       <= '0;
         pat_q       <= 4'hF;
         row_q       <= 2'd0;
         colx_q      <= 2'd0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
      end else begin
         case (state_q)
            SCAN: begin
               if (dwell_q == DWELL_LAST) begin
                  dwell_q <= '0;
                  if (!rows_idle_d) begin
                     pat_q   <= fs;
                     row_q   <= low_zero_idx(fs);
                     colx_q  <= low_zero_idx(col_q);
                     deb_q   <= '0;
                     state_q <= DEBOUNCE;
                  end else begin
                     col_q <= col_next_d;
                  end
               end else begin
                  dwell_q <= dwell_q + 1'b1;
               end
            end
            DEBOUNCE: begin
               // A bounce drops back to the same column with a fresh dwell.
               if (fs != pat_q) begin
                  deb_q   <= '0;
                  dwell_q <= '0;
                  state_q <= SCAN;
               end else if (deb_q == DEB_DONE) begin
                  key_code_q  <= KEYMAP[{row_q, colx_q}];
                  key_valid_q <= 1'b1;
                  deb_q       <= '0;
                  state_q     <= WAIT_ACK;
               end else begin
                  deb_q <= deb_q + 1'b1;
               end
            end
            WAIT_ACK: begin
               if (key_valid_q && key_ack) begin
                  key_valid_q <= 1'b0;
                  deb_q       <= '0;
                  state_q     <= RELEASE;
               end
            end
            RELEASE: begin
               if (!rows_idle_d) begin
                  deb_q <= '0;
               end else if (deb_q == REL_LAST) begin
                  deb_q   <= '0;
                  dwell_q <= '0;
                  col_q   <= col_next_d;
                  state_q <= SCAN;
               end else begin
                  deb_q <= deb_q + 1'b1;
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   assign col       = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_col_scan.sv
// Bench for keypad_col_scan: column-walk vector table, a keypad pin model and
// a scoreboard of expected key codes compared on each rising key_valid.
module tb_keypad_col_scan;

   localparam int SCAN_DIV   = 4;
   localparam int DEB_CYCLES = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_ack = 1'b0;
   logic [3:0] fil;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;

   logic       press_en    = 1'b0;
   logic       bounce_open = 1'b0;
   logic [1:0] press_col   = 2'd0;
   logic [3:0] press_rows  = 4'hF;

   int checks = 0;
   int passes = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_code;
   logic       prev_valid = 1'b0;

   typedef struct {
      logic       ack;
      logic [3:0] exp_col;
      logic       exp_valid;
   } vec_t;

   keypad_col_scan #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .fil       (fil),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ack   (key_ack)
   );

   always #5 clk = ~clk;

   // Pressed key pulls its rows low only while its column is driven.
   always_comb begin
      fil = 4'hF;
      if (press_en && !bounce_open && col[press_col] == 1'b0) fil = press_rows;
   end

   always @(negedge clk) begin
      if (key_valid && !prev_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_valid: got code %0h, no key expected", key_code);
         end else begin
            exp_code = exp_q.pop_front();
            if (key_code == exp_code) passes++;
            else $display("FAIL scoreboard_code: got %0h expected %0h", key_code, exp_code);
         end
      end
      prev_valid = key_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_col(input logic [3:0] target, input string name);
      int n = 0;
      while (col != target && n < 40) begin
         tick();
         n++;
      end
      check(name, col, target);
   endtask

   task automatic wait_valid(input int budget, input string name);
      int n = 0;
      while (!key_valid && n < budget) begin
         tick();
         n++;
      end
      check(name, key_valid, 1);
   endtask

   task automatic ack_pulse();
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
   endtask

   initial begin
      vec_t walk[20];
      logic [3:0] cseq[4];
      int   lat;
      logic ok;
      logic [3:0] c0;

      cseq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      for (int i = 0; i < 20; i++) begin
         walk[i].ack       = i[0];
         walk[i].exp_col   = cseq[(i / SCAN_DIV) % 4];
         walk[i].exp_valid = 1'b0;
      end

      rst = 1'b1;
      repeat (3) tick();
      check("reset_col", col, 4'b1110);
      check("reset_valid", key_valid, 0);
      check("reset_code", key_code, 4'h0);
      rst = 1'b0;

      // Column walk with no key; stray acks must be ignored while idle.
      for (int i = 0; i < 20; i++) begin
         key_ack = walk[i].ack;
         check($sformatf("walk_col[%0d]", i), col, walk[i].exp_col);
         check($sformatf("walk_valid[%0d]", i), key_valid, walk[i].exp_valid);
         tick();
      end
      key_ack = 1'b0;

      // Clean press r1,c2: detect on last dwell cycle, valid DEB_CYCLES+1 later.
      press_col  = 2'd2;
      press_rows = 4'b1101;
      exp_q.push_back(4'h6);
      press_en   = 1'b1;
      wait_col(4'b1011, "press_reach_col");
      lat = 0;
      ok  = 1'b1;
      while (!key_valid && lat < 40) begin
         tick();
         lat++;
         if (col != 4'b1011) ok = 1'b0;
      end
      check("press_latency", lat, SCAN_DIV + DEB_CYCLES + 1);
      check("press_col_frozen", ok, 1);
      check("press_code", key_code, 4'h6);

      // Held key without ack keeps valid and code stable.
      ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (!key_valid || key_code != 4'h6 || col != 4'b1011) ok = 1'b0;
      end
      check("hold_no_ack", ok, 1);
      ack_pulse();
      check("ack_clears_valid", key_valid, 0);
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (key_valid || col != 4'b1011) ok = 1'b0;
      end
      check("held_after_ack_quiet", ok, 1);
      press_en = 1'b0;
      lat = 0;
      while (col == 4'b1011 && lat < 40) begin
         tick();
         lat++;
      end
      // Two synchroniser edges, then DEB_CYCLES idle samples.
      check("release_latency", lat, DEB_CYCLES + 2);
      check("release_next_col", col, 4'b0111);

      // Bounce on r1,c0: never stable for DEB_CYCLES.
      press_col  = 2'd0;
      press_rows = 4'b1101;
      press_en   = 1'b1;
      ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         bounce_open = ((k / 3) % 2) == 1;
         tick();
         if (key_valid) ok = 1'b0;
      end
      press_en    = 1'b0;
      bounce_open = 1'b0;
      check("bounce_no_valid", ok, 1);
      c0 = col;
      lat = 0;
      while (col == c0 && lat < 20) begin
         tick();
         lat++;
      end
      check("bounce_scan_resumes", (col != c0), 1);

      // Two rows on c3: lowest row wins.
      press_col  = 2'd3;
      press_rows = 4'b0110;
      exp_q.push_back(4'hA);
      press_en   = 1'b1;
      wait_valid(60, "multi_valid");
      check("multi_code", key_code, 4'hA);
      ack_pulse();
      press_en = 1'b0;
      wait_col(4'b1110, "multi_release_col");

      // Reset while the debounce count is 5.
      press_col  = 2'd1;
      press_rows = 4'b1011;
      press_en   = 1'b1;
      wait_col(4'b1101, "rst_reach_col");
      repeat (SCAN_DIV + 5) tick();
      check("rst_pre_valid", key_valid, 0);
      rst = 1'b1;
      tick();
      check("rst_mid_col", col, 4'b1110);
      check("rst_mid_valid", key_valid, 0);
      check("rst_mid_code", key_code, 4'h0);
      rst = 1'b0;
      exp_q.push_back(4'h8);
      wait_valid(80, "after_rst_valid");
      check("after_rst_code", key_code, 4'h8);
      ack_pulse();
      press_en = 1'b0;
      repeat (DEB_CYCLES + 4) tick();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
